// File: rtl/sobel_linebuf.sv
// sobel_linebuf: two-line buffer that turns a raster pixel stream into interior 3x3 windows for sobel_E
// Ports:
//   CLOCK, RESET                  single clock, synchronous active-high reset
//   pix_in, pix_valid, pix_ready  raster-order input pixel stream
//   input_row_a00/a01/a02         window rows (lines r-2 / r-1 / r); column c-2 in the MSBs, column c in the LSBs
//   win_valid, win_ready          output window handshake, one window per transfer
//   frame_done                    one-cycle pulse after the last window of a frame is taken
// Optional: define SOBEL_LB_FRAME_CNT_EN to add frame_cnt[15:0], a wrapping count of frame_done pulses.
module sobel_linebuf #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [3*PIX_W-1:0] input_row_a00,
    output logic [3*PIX_W-1:0] input_row_a01,
    output logic [3*PIX_W-1:0] input_row_a02,
    output logic               win_valid,
    input  logic               win_ready,
`ifdef SOBEL_LB_FRAME_CNT_EN
    output logic [15:0]        frame_cnt,
`endif
    output logic               frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = 3 * PIX_W;
    typedef enum logic {PRIME, STREAM} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [WW-1:0] wt_q, wt_d, wm_q, wm_d, wb_q, wb_d;
    logic [WW-1:0] a00_q, a00_d, a01_q, a01_d, a02_q, a02_d;
    logic win_valid_q, win_valid_d, last_q, last_d, frame_done_q, frame_done_d;
    logic accept, load, hs, col_end, row_end;
    logic [PIX_W-1:0] t, m;
    assign pix_ready = !win_valid_q || win_ready;
    always_comb begin
        accept = pix_valid && pix_ready;
        hs = win_valid_q && win_ready;
        col_end = col_q == CW'(IMG_W - 1);
        row_end = row_q == RW'(IMG_H - 1);
        t = lb0_q[col_q];
        m = lb1_q[col_q];
        load = accept && state_q == STREAM && col_q >= CW'(2);
        col_d = accept ? (col_end ? '0 : col_q + CW'(1)) : col_q;
        row_d = (accept && col_end) ? (row_end ? '0 : row_q + RW'(1)) : row_q;
        state_d = (accept && col_end && state_q == PRIME && row_q == RW'(1)) ? STREAM :
                  (accept && col_end && state_q == STREAM && row_end) ? PRIME : state_q;
        // new column {t, m, pix_in} enters at the right; oldest column falls off the MSBs
        wt_d = accept ? {wt_q[2*PIX_W-1:0], t} : wt_q;
        wm_d = accept ? {wm_q[2*PIX_W-1:0], m} : wm_q;
        wb_d = accept ? {wb_q[2*PIX_W-1:0], pix_in} : wb_q;
        a00_d = load ? wt_d : a00_q;
        a01_d = load ? wm_d : a01_q;
        a02_d = load ? wb_d : a02_q;
        win_valid_d = load || (win_valid_q && !win_ready);
        // last_q marks that the window currently presented is the frame's final one
        last_d = load ? (row_end && col_end) : (hs ? 1'b0 : last_q);
        frame_done_d = hs && last_q;
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= PRIME;
            col_q <= '0;
            row_q <= '0;
            wt_q <= '0;
            wm_q <= '0;
            wb_q <= '0;
            a00_q <= '0;
            a01_q <= '0;
            a02_q <= '0;
            win_valid_q <= 1'b0;
            last_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            row_q <= row_d;
            wt_q <= wt_d;
            wm_q <= wm_d;
            wb_q <= wb_d;
            a00_q <= a00_d;
            a01_q <= a01_d;
            a02_q <= a02_d;
            win_valid_q <= win_valid_d;
            last_q <= last_d;
            frame_done_q <= frame_done_d;
        end
    end
    // line RAM is never cleared: every entry is rewritten during rows 0-1 before it is used in a window
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            lb0_q[col_q] <= m;
            lb1_q[col_q] <= pix_in;
        end
    end
`ifdef SOBEL_LB_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge CLOCK) begin
        if (RESET) frame_cnt_q <= '0;
        else if (frame_done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
`endif
    assign input_row_a00 = a00_q;
    assign input_row_a01 = a01_q;
    assign input_row_a02 = a02_q;
    assign win_valid = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_linebuf.sv
// tb_sobel_linebuf: directed bench for sobel_linebuf on a 4x4 image
module tb_sobel_linebuf;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic [7:0] pix_in = '0;
    logic pix_valid = 1'b0;
    logic pix_ready;
    logic [23:0] a00, a01, a02;
    logic win_valid;
    logic win_ready = 1'b1;
    logic frame_done;
`ifdef SOBEL_LB_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif
    int checks = 0;
    int errors = 0;
    int wins = 0;
    int fdn = 0;
    int fc = 0;
    logic [72:0] expq [$];
    sobel_linebuf #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .input_row_a00(a00),
        .input_row_a01(a01),
        .input_row_a02(a02),
        .win_valid(win_valid),
        .win_ready(win_ready),
`ifdef SOBEL_LB_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_done(frame_done)
    );
    always #5 CLOCK = ~CLOCK;
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [23:0] row3(input int v);
        return {8'(v), 8'(v + 1), 8'(v + 2)};
    endfunction
    // one clock: drive inputs, score any handshake, then check registered results after the edge
    task automatic tick(input logic pv, input int px, input logic wr, input bit lat, input int pos, output bit acc);
        logic [72:0] e;
        bit exp_fd;
        bit exp_ld;
        pix_valid = pv;
        pix_in = 8'(px);
        win_ready = wr;
        #1;
        acc = pv && pix_ready;
        exp_fd = 0;
        if (win_valid && wr) begin
            check("win_expected", 72'(expq.size() != 0), 72'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("window", {a00, a01, a02}, e[71:0]);
                exp_fd = e[72];
                wins++;
            end
        end
        exp_ld = acc && pos >= 0 && pos / 4 >= 2 && pos % 4 >= 2;
        @(posedge CLOCK);
        #1;
        check("frame_done", 72'(frame_done), 72'(exp_fd));
        if (lat) check("win_valid_latency", 72'(win_valid), 72'(exp_ld));
        if (frame_done) begin
            fdn++;
            fc++;
        end
`ifdef SOBEL_LB_FRAME_CNT_EN
        check("frame_cnt", 72'(frame_cnt), 72'(fc & 16'hFFFF));
`endif
    endtask
    task automatic do_reset();
        RESET = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        expq.delete();
        wins = 0;
        fdn = 0;
        fc = 0;
        check("rst_win_valid", 72'(win_valid), 72'd0);
        check("rst_frame_done", 72'(frame_done), 72'd0);
        check("rst_rows", {a00, a01, a02}, 72'd0);
        check("rst_pix_ready", 72'(pix_ready), 72'd1);
`ifdef SOBEL_LB_FRAME_CNT_EN
        check("rst_frame_cnt", 72'(frame_cnt), 72'd0);
`endif
    endtask
    // mode 0: continuous; 1: win_ready low 3 cycles after first win_valid; 2: pix_valid toggling
    task automatic run_frame(input int base, input int mode);
        int tl;
        int p = 0;
        int n = 0;
        int stall = 0;
        bit used = 0;
        bit tog = 1;
        bit acc;
        logic [71:0] held;
        for (int k = 0; k < 4; k++) begin
            tl = base + (k / 2) * 4 + k % 2;
            expq.push_back({k == 3, row3(tl), row3(tl + 4), row3(tl + 8)});
        end
        while (p < 16 && n < 200) begin
            n++;
            if (mode == 1 && !used && win_valid) begin
                stall = 3;
                used = 1;
            end
            held = {a00, a01, a02};
            tick(mode == 2 ? tog : 1'b1, base + p, stall == 0, mode != 1, p, acc);
            tog = !tog;
            if (stall > 0) begin
                check("stall_hold", {a00, a01, a02}, held);
                check("stall_valid", 72'(win_valid), 72'd1);
                check("stall_pix_ready", 72'(pix_ready), 72'd0);
                stall--;
            end
            if (acc) p++;
        end
        check("frame_fed", 72'(p), 72'd16);
    endtask
    task automatic drain();
        bit acc;
        for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b1, 1'b1, -1, acc);
    endtask
    initial begin
        bit acc;
        do_reset();
        run_frame(0, 0);
        drain();
        check("t1_windows", 72'(wins), 72'd4);
        check("t1_frame_done", 72'(fdn), 72'd1);
        do_reset();
        run_frame(0, 1);
        drain();
        check("t2_windows", 72'(wins), 72'd4);
        check("t2_frame_done", 72'(fdn), 72'd1);
        do_reset();
        run_frame(0, 0);
        run_frame(100, 0);
        drain();
        check("t3_windows", 72'(wins), 72'd8);
        check("t3_frame_done", 72'(fdn), 72'd2);
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, i, 1'b1, 1'b1, i, acc);
        do_reset();
        run_frame(0, 0);
        drain();
        check("t4_windows", 72'(wins), 72'd4);
        check("t4_frame_done", 72'(fdn), 72'd1);
        do_reset();
        run_frame(0, 2);
        drain();
        check("t5_windows", 72'(wins), 72'd4);
        check("t5_frame_done", 72'(fdn), 72'd1);
`ifdef SOBEL_LB_FRAME_CNT_EN
        do_reset();
        run_frame(0, 0);
        run_frame(50, 0);
        run_frame(100, 0);
        drain();
        check("t6_frame_cnt", 72'(frame_cnt), 72'd3);
        do_reset();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_linebuf.md
Name: sobel_linebuf

Overview:
Upstream window generator for sobel_E. Accepts a raster-order pixel stream, buffers two previous image lines, and emits 3x3 windows as three packed row words. Those words drive sobel_E's input_row_a00/a01/a02 ports directly, one window per valid/ready handshake. Only interior windows are emitted: (IMG_H-2)*(IMG_W-2) per frame.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 64, pixels per line (>=3)
IMG_H, 64, lines per frame (>=3)

Ports:
CLOCK  in  1  single clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
pix_in  in  PIX_W  input pixel, raster order
pix_valid  in  1  pix_in valid
pix_ready  out  1  block can accept pix_in this cycle
input_row_a00  out  3*PIX_W  window top row (line r-2); [3*PIX_W-1 -: PIX_W] = column c-2, [PIX_W-1:0] = column c
input_row_a01  out  3*PIX_W  window middle row (line r-1), same packing
input_row_a02  out  3*PIX_W  window bottom row (line r), same packing
win_valid  out  1  window outputs valid
win_ready  in  1  downstream accepts window
frame_done  out  1  one-cycle pulse when the last window of a frame is accepted

Behaviour:
- Reset (synchronous, RESET=1 at a rising edge): col=0, row=0, state=PRIME, win_valid=0, frame_done=0, all row outputs=0, window shift registers=0. Line-buffer RAM contents are not cleared; they are never read before being rewritten in a frame.
- pix_ready = !win_valid || win_ready. Single output register, no skid buffer.
- Accept: pix_valid && pix_ready at an edge. Only accepts advance col/row and buffers.
- Line buffers: two arrays, lb0 and lb1, each IMG_W deep, combinational read.
  - On an accept at column c: read t=lb0[c] (line r-2) and m=lb1[c] (line r-1).
  - Then write lb0[c]<=m and lb1[c]<=pix_in.
- Window: 3x3 shift register. On accept, each row shifts left one column and the new column {t,m,pix_in} enters at the right (index c).
- Counters: col counts 0..IMG_W-1 and wraps to 0, incrementing row. row counts 0..IMG_H-1 and wraps to 0 with frame restart. Back-to-back frames need no gap.
- FSM:
  - PRIME (row<2): accepts pixels and never asserts win_valid. Moves to STREAM on the accept of pixel (row=1, col=IMG_W-1).
  - STREAM: on an accept with col>=2, the output registers load the updated window and win_valid<=1 on the same edge. Latency is one cycle from accept to win_valid.
  - STREAM -> PRIME on the accept of pixel (IMG_H-1, IMG_W-1). That final window is still emitted.
- Output hold: while win_valid && !win_ready, outputs are held stable and pix_ready=0.
- Handshake clear: win_valid && win_ready with no new interior accept on the same edge clears win_valid. A simultaneous handshake and new interior accept reloads the outputs with win_valid staying 1, giving full throughput.
- Columns 0-1 of each line never produce a window. Rows 0-1 never do either.
- frame_done: registered pulse on the edge after the window-handshake of window (IMG_H-1, IMG_W-1).
- Reset mid-frame: takes effect immediately. Any partial frame and pending window are discarded, and the next pixel is treated as (0,0).
- No arithmetic. Outputs are raw PIX_W slices, unsigned and unchanged.

Optional Feature:
Macro SOBEL_LB_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0].
  - Reset value is 0.
  - Increments on the same edge that frame_done asserts, and wraps 0xFFFF->0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15, win_ready=1 continuous -> exactly 4 windows, frame_done pulses once. Expected windows (a00 / a01 / a02, column c-2 first):
  - Window 1: {0,1,2} / {4,5,6} / {8,9,10}
  - Window 2: {1,2,3} / {5,6,7} / {9,10,11}
  - Window 3: {4,5,6} / {8,9,10} / {12,13,14}
  - Window 4: {5,6,7} / {9,10,11} / {13,14,15}
- Same frame with win_ready=0 for 3 cycles after the first win_valid -> pix_ready=0 and outputs stable for those cycles. No pixel is lost and the window sequence is unchanged.
- Two frames back-to-back (0..15, then 100..115) -> 8 windows. The 5th window is {100,101,102}/{104,105,106}/{108,109,110}, and frame_done pulses twice.
- Assert RESET for one cycle after pixel 9 -> no window from the partial frame. A fresh frame 0..15 then yields exactly the 4 windows above.
- pix_valid toggling 1/0 every cycle with win_ready=1 -> identical window values. win_valid asserts one cycle after each interior accept.
- With SOBEL_LB_FRAME_CNT_EN, 3 frames -> frame_cnt reads 1, 2, 3 after each frame_done. Reset returns it to 0.
